// File: rtl/heap_pkg.sv
// Shared encodings for the binary-heap priority queue: request opcodes and sift FSM states.
package heap_pkg;

  localparam logic [1:0] OP_PUSH    = 2'b00;
  localparam logic [1:0] OP_POP     = 2'b01;
  localparam logic [1:0] OP_REPLACE = 2'b10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SIFT_UP   = 2'd1,
    SIFT_DOWN = 2'd2
  } state_t;

endpackage

// File: rtl/heap_cmp.sv
// Heap ordering compare: picks the better of two children and flags a swap when it beats the current node.
// Combinational; shared by both sift directions (sift-up uses only the left input).
module heap_cmp #(
  parameter int DATA_W   = 32,
  parameter int MAX_HEAP = 1
) (
  input  logic [DATA_W-1:0] cur_key,
  input  logic [DATA_W-1:0] l_key,
  input  logic [DATA_W-1:0] r_key,
  input  logic              l_ok,
  input  logic              r_ok,
  output logic [DATA_W-1:0] best_key,
  output logic              swap
);

  // Strict ordering so equal keys never move.
  function automatic logic better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (MAX_HEAP != 0) return a > b;
    return a < b;
  endfunction

  logic r_wins;

  assign r_wins   = r_ok && better(r_key, l_key);
  assign best_key = r_wins ? r_key : l_key;
  assign swap     = l_ok && better(best_key, cur_key);

endmodule

// File: rtl/heap_pq.sv
// Binary-heap priority queue; one request per IDLE cycle, then 1 sift level per cycle (<= log2(DEPTH) cycles busy).
// req_ready is low while sifting; define HEAP_REPLACE_EN to enable the replace (op 10) operation.
module heap_pq
  import heap_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int MAX_HEAP = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_op,
  input  logic [DATA_W-1:0]          req_key,
  output logic                       resp_valid,
  output logic [DATA_W-1:0]          resp_key,
  output logic                       err,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic [DATA_W-1:0]          top_key
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = AW + 1;

  logic [DATA_W-1:0] arr [DEPTH];

  state_t            state, state_nxt;
  logic [IW-1:0]     cnt, cnt_nxt, idx, idx_nxt, l_idx, r_idx, child;
  logic [AW-1:0]     par, last;
  logic              we0, we1;
  logic [AW-1:0]     wa0, wa1;
  logic [DATA_W-1:0] wd0, wd1;
  logic              resp_nxt, err_nxt;
  logic [DATA_W-1:0] rkey_nxt, up_key, dn_key;
  logic              up_swap, dn_swap;

  assign par       = AW'((idx - IW'(1)) >> 1);
  assign last      = cnt[AW-1:0] - AW'(1);
  assign l_idx     = (idx << 1) + IW'(1);
  assign r_idx     = (idx << 1) + IW'(2);
  assign req_ready = (state == IDLE);
  assign count     = cnt;

  heap_cmp #(.DATA_W(DATA_W), .MAX_HEAP(MAX_HEAP)) u_cmp_up (
    .cur_key (arr[par]),
    .l_key   (arr[idx[AW-1:0]]),
    .r_key   ('0),
    .l_ok    (idx != '0),
    .r_ok    (1'b0),
    .best_key(up_key),
    .swap    (up_swap)
  );

  heap_cmp #(.DATA_W(DATA_W), .MAX_HEAP(MAX_HEAP)) u_cmp_dn (
    .cur_key (arr[idx[AW-1:0]]),
    .l_key   (arr[l_idx[AW-1:0]]),
    .r_key   (arr[r_idx[AW-1:0]]),
    .l_ok    (l_idx < cnt),
    .r_ok    (r_idx < cnt),
    .best_key(dn_key),
    .swap    (dn_swap)
  );

  // Right child won only if it differs from the left key (ties resolve left).
  assign child = ((r_idx < cnt) && (dn_key != arr[l_idx[AW-1:0]])) ? r_idx : l_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    resp_nxt  = 1'b0;
    rkey_nxt  = resp_key;
    err_nxt   = 1'b0;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_PUSH: begin
              if (cnt != IW'(DEPTH)) begin
                we0 = 1'b1; wa0 = cnt[AW-1:0]; wd0 = req_key;
                cnt_nxt = cnt + IW'(1);
                idx_nxt = cnt;
                if (cnt != '0) state_nxt = SIFT_UP;
              end else begin
                err_nxt = 1'b1;
              end
            end
            OP_POP: begin
              if (cnt != '0) begin
                resp_nxt = 1'b1; rkey_nxt = arr[0];
                we0 = 1'b1; wa0 = '0; wd0 = arr[last];
                cnt_nxt = cnt - IW'(1);
                idx_nxt = '0;
                if (cnt > IW'(2)) state_nxt = SIFT_DOWN;
              end else begin
                err_nxt = 1'b1;
              end
            end
            OP_REPLACE: begin
`ifdef HEAP_REPLACE_EN
              we0 = 1'b1; wa0 = '0; wd0 = req_key;
              idx_nxt = '0;
              if (cnt == '0) begin
                cnt_nxt = IW'(1);
              end else begin
                resp_nxt = 1'b1; rkey_nxt = arr[0];
                state_nxt = SIFT_DOWN;
              end
`else
              err_nxt = 1'b1;
`endif
            end
            default: err_nxt = 1'b1;
          endcase
        end
      end
      SIFT_UP: begin
        if (up_swap) begin
          we0 = 1'b1; wa0 = idx[AW-1:0]; wd0 = arr[par];
          we1 = 1'b1; wa1 = par;         wd1 = up_key;
          idx_nxt = {1'b0, par};
        end else begin
          state_nxt = IDLE;
        end
      end
      SIFT_DOWN: begin
        if (dn_swap) begin
          we0 = 1'b1; wa0 = idx[AW-1:0];   wd0 = dn_key;
          we1 = 1'b1; wa1 = child[AW-1:0]; wd1 = arr[idx[AW-1:0]];
          idx_nxt = child;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      resp_valid <= 1'b0;
      resp_key   <= '0;
      err        <= 1'b0;
      full       <= 1'b0;
      empty      <= 1'b1;
      top_key    <= '0;
    end else begin
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      resp_valid <= resp_nxt;
      resp_key   <= rkey_nxt;
      err        <= err_nxt;
      full       <= (cnt_nxt == IW'(DEPTH));
      empty      <= (cnt_nxt == '0);
      // top_key shadows every write that lands on entry 0.
      if (we1 && wa1 == '0)      top_key <= wd1;
      else if (we0 && wa0 == '0) top_key <= wd0;
    end
  end

  // Storage is deliberately not reset; count alone defines validity.
  always_ff @(posedge clk) begin
    if (we0) arr[wa0] <= wd0;
    if (we1) arr[wa1] <= wd1;
  end

endmodule

// File: tb/tb_heap_pq.sv
// Bench for heap_pq: a 16-entry max-heap and a 4-entry min-heap checked against an unordered-bag model.
module tb_heap_pq;

  localparam int DW   = 8;
  localparam int DEP0 = 16;
  localparam int DEP1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          req_valid [2];
  logic [1:0]    req_op    [2];
  logic [DW-1:0] req_key   [2];
  logic          req_ready [2];
  logic          resp_valid[2];
  logic          err       [2];
  logic          full      [2];
  logic          empty     [2];
  logic [DW-1:0] resp_key  [2];
  logic [DW-1:0] top_key   [2];
  logic [4:0]    count0;
  logic [2:0]    count1;

  int total = 0;
  int bad   = 0;
  int mk [2][16];
  int mn [2];

  heap_pq #(.DATA_W(DW), .DEPTH(DEP0), .MAX_HEAP(1)) u_max (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_op(req_op[0]), .req_key(req_key[0]), .resp_valid(resp_valid[0]), .resp_key(resp_key[0]),
    .err(err[0]), .count(count0), .full(full[0]), .empty(empty[0]), .top_key(top_key[0])
  );

  heap_pq #(.DATA_W(DW), .DEPTH(DEP1), .MAX_HEAP(0)) u_min (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_op(req_op[1]), .req_key(req_key[1]), .resp_valid(resp_valid[1]), .resp_key(resp_key[1]),
    .err(err[1]), .count(count1), .full(full[1]), .empty(empty[1]), .top_key(top_key[1])
  );

  function automatic logic [4:0] cnt_of(input int d);
    return (d == 0) ? count0 : {2'b00, count1};
  endfunction

  function automatic int cap(input int d);
    return (d == 0) ? DEP0 : DEP1;
  endfunction

  // Dut 0 keeps its largest key on top, dut 1 its smallest.
  function automatic int m_best(input int d);
    int b = 0;
    for (int i = 1; i < mn[d]; i++)
      if ((d == 0) ? (mk[d][i] > mk[d][b]) : (mk[d][i] < mk[d][b])) b = i;
    return mk[d][b];
  endfunction

  task automatic m_push(input int d, input int k);
    mk[d][mn[d]] = k;
    mn[d]++;
  endtask

  task automatic m_pop(input int d, output int k);
    int b = 0;
    for (int i = 1; i < mn[d]; i++)
      if ((d == 0) ? (mk[d][i] > mk[d][b]) : (mk[d][i] < mk[d][b])) b = i;
    k = mk[d][b];
    mk[d][b] = mk[d][mn[d]-1];
    mn[d]--;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    mn[0] = 0;
    mn[1] = 0;
    @(negedge clk);
  endtask

  task automatic issue(input int d, input logic [1:0] op, input int key,
                       output logic rv, output int rk, output logic er);
    int n = 0;
    while (req_ready[d] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    req_valid[d] = 1'b1;
    req_op[d]    = op;
    req_key[d]   = DW'(key);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    @(negedge clk);
    rv = resp_valid[d];
    rk = int'(resp_key[d]);
    er = err[d];
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    total++;
    if (n >= 50) begin bad++; $display("FAIL op_timeout dut=%0d op=%0d got=busy expected=idle", d, op); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin req_valid[d] = 1'b0; req_op[d] = 2'b00; req_key[d] = '0; end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mn[0] = 0;
    mn[1] = 0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++; if (cnt_of(d) !== 5'd0) begin bad++; $display("FAIL reset_count dut=%0d got=%0d expected=0", d, cnt_of(d)); end
      total++; if (empty[d] !== 1'b1) begin bad++; $display("FAIL reset_empty dut=%0d got=%b expected=1", d, empty[d]); end
      total++; if (full[d] !== 1'b0) begin bad++; $display("FAIL reset_full dut=%0d got=%b expected=0", d, full[d]); end
      total++; if (resp_valid[d] !== 1'b0 || err[d] !== 1'b0) begin bad++; $display("FAIL reset_pulses dut=%0d got=%b%b expected=00", d, resp_valid[d], err[d]); end
      total++; if (resp_key[d] !== '0 || top_key[d] !== '0) begin bad++; $display("FAIL reset_keys dut=%0d got=%0d/%0d expected=0/0", d, resp_key[d], top_key[d]); end
      total++; if (req_ready[d] !== 1'b1) begin bad++; $display("FAIL reset_ready dut=%0d got=%b expected=1", d, req_ready[d]); end
    end
  endtask

  task automatic test_max_order();
    int ks[4] = '{5, 9, 1, 7};
    logic rv, er;
    int rk, ek;
    foreach (ks[i]) begin issue(0, 2'b00, ks[i], rv, rk, er); m_push(0, ks[i]); end
    total++; if (top_key[0] !== 8'd9) begin bad++; $display("FAIL max_top got=%0d expected=9", top_key[0]); end
    total++; if (count0 !== 5'd4) begin bad++; $display("FAIL max_count got=%0d expected=4", count0); end
    for (int i = 0; i < 4; i++) begin
      issue(0, 2'b01, 0, rv, rk, er);
      m_pop(0, ek);
      total++; if (rv !== 1'b1 || rk != ek) begin bad++; $display("FAIL max_pop%0d got=%0d valid=%b expected=%0d", i, rk, rv, ek); end
    end
    total++; if (empty[0] !== 1'b1) begin bad++; $display("FAIL max_drained got=%b expected=1", empty[0]); end
  endtask

  task automatic test_min_order();
    int ks[3] = '{5, 9, 1};
    logic rv, er;
    int rk, ek;
    foreach (ks[i]) begin issue(1, 2'b00, ks[i], rv, rk, er); m_push(1, ks[i]); end
    total++; if (top_key[1] !== 8'd1) begin bad++; $display("FAIL min_top got=%0d expected=1", top_key[1]); end
    issue(1, 2'b01, 0, rv, rk, er);
    m_pop(1, ek);
    total++; if (rv !== 1'b1 || rk != ek) begin bad++; $display("FAIL min_pop got=%0d valid=%b expected=%0d", rk, rv, ek); end
    total++; if (int'(top_key[1]) != m_best(1)) begin bad++; $display("FAIL min_top_after got=%0d expected=%0d", top_key[1], m_best(1)); end
  endtask

  task automatic test_full_empty();
    logic rv, er;
    int rk, ek, k;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      k = int'($urandom_range(0, 31));
      issue(1, 2'b00, k, rv, rk, er);
      m_push(1, k);
    end
    total++; if (full[1] !== 1'b1) begin bad++; $display("FAIL fe_full got=%b expected=1", full[1]); end
    issue(1, 2'b00, 7, rv, rk, er);
    total++; if (er !== 1'b1 || rv !== 1'b0) begin bad++; $display("FAIL fe_push_full got err=%b rv=%b expected err=1 rv=0", er, rv); end
    total++; if (count1 !== 3'd4) begin bad++; $display("FAIL fe_count_full got=%0d expected=4", count1); end
    for (int i = 0; i < 4; i++) begin
      issue(1, 2'b01, 0, rv, rk, er);
      m_pop(1, ek);
      total++; if (rv !== 1'b1 || rk != ek) begin bad++; $display("FAIL fe_pop%0d got=%0d expected=%0d", i, rk, ek); end
    end
    issue(1, 2'b01, 0, rv, rk, er);
    total++; if (er !== 1'b1 || rv !== 1'b0) begin bad++; $display("FAIL fe_pop_empty got err=%b rv=%b expected err=1 rv=0", er, rv); end
    @(negedge clk);
    total++; if (err[1] !== 1'b0) begin bad++; $display("FAIL fe_err_pulse got=%b expected=0", err[1]); end
    total++; if (count1 !== 3'd0 || empty[1] !== 1'b1) begin bad++; $display("FAIL fe_count_empty got=%0d expected=0", count1); end
  endtask

  task automatic test_duplicates();
    logic rv, er;
    int rk;
    for (int i = 0; i < 3; i++) begin issue(0, 2'b00, 3, rv, rk, er); m_push(0, 3); end
    for (int i = 0; i < 3; i++) begin
      issue(0, 2'b01, 0, rv, rk, er);
      total++; if (rv !== 1'b1 || rk != 3 || er !== 1'b0) begin bad++; $display("FAIL dup_pop%0d got=%0d err=%b expected=3 err=0", i, rk, er); end
    end
    mn[0] = 0;
  endtask

  task automatic test_reserved_op();
    logic rv, er;
    int rk;
    issue(0, 2'b00, 4, rv, rk, er);
    issue(0, 2'b11, 9, rv, rk, er);
    total++; if (er !== 1'b1 || rv !== 1'b0) begin bad++; $display("FAIL reserved_err got err=%b rv=%b expected err=1 rv=0", er, rv); end
    total++; if (count0 !== 5'd1 || top_key[0] !== 8'd4) begin bad++; $display("FAIL reserved_state got=%0d/%0d expected=1/4", count0, top_key[0]); end
    issue(0, 2'b01, 0, rv, rk, er);
  endtask

  task automatic test_replace();
    int ks[3] = '{8, 6, 4};
    logic rv, er;
    int rk;
    pulse_reset();
    foreach (ks[i]) issue(0, 2'b00, ks[i], rv, rk, er);
    issue(0, 2'b10, 5, rv, rk, er);
`ifdef HEAP_REPLACE_EN
    total++; if (rv !== 1'b1 || rk != 8 || er !== 1'b0) begin bad++; $display("FAIL repl_resp got=%0d rv=%b expected=8 rv=1", rk, rv); end
    total++; if (top_key[0] !== 8'd6 || count0 !== 5'd3) begin bad++; $display("FAIL repl_state got=%0d/%0d expected=6/3", top_key[0], count0); end
    issue(1, 2'b10, 11, rv, rk, er);
    total++; if (rv !== 1'b0 || er !== 1'b0 || count1 !== 3'd1 || top_key[1] !== 8'd11) begin bad++; $display("FAIL repl_empty got rv=%b err=%b cnt=%0d top=%0d expected 0 0 1 11", rv, er, count1, top_key[1]); end
`else
    total++; if (er !== 1'b1 || rv !== 1'b0) begin bad++; $display("FAIL repl_off_err got err=%b rv=%b expected err=1 rv=0", er, rv); end
    total++; if (top_key[0] !== 8'd8 || count0 !== 5'd3) begin bad++; $display("FAIL repl_off_state got=%0d/%0d expected=8/3", top_key[0], count0); end
`endif
  endtask

  task automatic test_random(input int d, input int n);
    logic rv, er, exp_rv, exp_er;
    logic [1:0] op;
    int rk, exp_rk, key, r;
    pulse_reset();
    for (int i = 0; i < n; i++) begin
      r   = int'($urandom_range(0, 19));
      op  = (r < 9) ? 2'b00 : (r < 17) ? 2'b01 : (r < 19) ? 2'b10 : 2'b11;
      key = int'($urandom_range(0, 31));
      exp_rv = 1'b0; exp_er = 1'b0; exp_rk = 0;
      case (op)
        2'b00: if (mn[d] == cap(d)) exp_er = 1'b1; else m_push(d, key);
        2'b01: if (mn[d] == 0) exp_er = 1'b1; else begin exp_rv = 1'b1; m_pop(d, exp_rk); end
`ifdef HEAP_REPLACE_EN
        2'b10: if (mn[d] == 0) m_push(d, key); else begin exp_rv = 1'b1; m_pop(d, exp_rk); m_push(d, key); end
`endif
        default: exp_er = 1'b1;
      endcase
      issue(d, op, key, rv, rk, er);
      total++; if (er !== exp_er || rv !== exp_rv) begin bad++; $display("FAIL rand_flags dut=%0d i=%0d op=%0d got=%b%b expected=%b%b", d, i, op, er, rv, exp_er, exp_rv); end
      if (exp_rv) begin
        total++; if (rk != exp_rk) begin bad++; $display("FAIL rand_key dut=%0d i=%0d got=%0d expected=%0d", d, i, rk, exp_rk); end
      end
      total++; if (cnt_of(d) !== 5'(mn[d]) || empty[d] !== (mn[d] == 0) || full[d] !== (mn[d] == cap(d))) begin bad++; $display("FAIL rand_count dut=%0d i=%0d got=%0d expected=%0d", d, i, cnt_of(d), mn[d]); end
      if (mn[d] > 0) begin
        total++; if (int'(top_key[d]) != m_best(d)) begin bad++; $display("FAIL rand_top dut=%0d i=%0d got=%0d expected=%0d", d, i, top_key[d], m_best(d)); end
      end
    end
  endtask

  task automatic test_reset_mid_sift();
    logic rv, er;
    int rk;
    pulse_reset();
    for (int i = 0; i < 8; i++) issue(0, 2'b00, int'($urandom_range(10, 60)), rv, rk, er);
    req_valid[0] = 1'b1;
    req_op[0]    = 2'b01;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    total++; if (req_ready[0] !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b expected=0", req_ready[0]); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mn[0] = 0;
    mn[1] = 0;
    total++; if (count0 !== 5'd0 || req_ready[0] !== 1'b1) begin bad++; $display("FAIL mid_reset got cnt=%0d rdy=%b expected cnt=0 rdy=1", count0, req_ready[0]); end
    issue(0, 2'b00, 2, rv, rk, er);
    total++; if (top_key[0] !== 8'd2 || count0 !== 5'd1 || er !== 1'b0) begin bad++; $display("FAIL mid_push got top=%0d cnt=%0d expected top=2 cnt=1", top_key[0], count0); end
  endtask

  initial begin
    test_reset();
    test_max_order();
    test_min_order();
    test_full_empty();
    test_duplicates();
    test_reserved_op();
    test_replace();
    test_random(0, 150);
    test_random(1, 150);
    test_reset_mid_sift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/heap_pq.md
HEAP_PQ -- requirements
Module: heap_pq

Interface
REQ-001 Parameter DATA_W, 32, key width in bits.
REQ-002 Parameter DEPTH, 1024, maximum entry count; power of two, at least 4.
REQ-003 Parameter MAX_HEAP, 1, ordering mode: 1 = largest key on top, 0 = smallest key on top.
REQ-004 Port clk  input  1  single clock; all logic is on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port req_valid  input  1  request present.
REQ-007 Port req_ready  output  1  block can accept a request.
REQ-008 Port req_op  input  2  operation: 00 = push, 01 = pop, 10 = replace (`HEAP_REPLACE_EN` only), 11 = reserved.
REQ-009 Port req_key  input  DATA_W  key for push or replace.
REQ-010 Port resp_valid  output  1  one-cycle pulse; resp_key is valid.
REQ-011 Port resp_key  output  DATA_W  key removed by a pop or replace.
REQ-012 Port err  output  1  one-cycle pulse on a rejected request.
REQ-013 Port count  output  $clog2(DEPTH+1)  current number of entries.
REQ-014 Port full  output  1  count == DEPTH.
REQ-015 Port empty  output  1  count == 0.
REQ-016 Port top_key  output  DATA_W  entry 0; valid only when empty == 0.

Function
REQ-017 A request is accepted in a cycle where req_valid and req_ready are both 1; req_ready == 1 only in state IDLE.
REQ-018 The FSM has three states: IDLE, SIFT_UP, SIFT_DOWN.
REQ-019 "Better(a,b)" is a strict comparison (a>b if MAX_HEAP, a<b otherwise); equal keys are never swapped.
REQ-020 Push (not full), accept cycle: arr[count] <= key; count increments; idx <= old count; next state is SIFT_UP if old count > 0, else IDLE.
REQ-021 SIFT_UP, one level per cycle, parent = (idx-1)>>1:
- if idx != 0 and Better(arr[idx], arr[parent]): swap the two entries and set idx <= parent;
- otherwise go to IDLE.
REQ-022 Pop (not empty), accept cycle: resp_key <= arr[0] with resp_valid pulsed the next cycle; arr[0] <= arr[count-1]; count decrements; idx <= 0; next state is SIFT_DOWN if new count > 1, else IDLE.
REQ-023 SIFT_DOWN, one level per cycle, children l = 2idx+1 and r = 2idx+2, considered only if < count:
- pick the better child;
- if it is Better than arr[idx], swap and set idx <= child;
- otherwise go to IDLE.
REQ-024 Worst-case occupancy per operation is 1 + log2(DEPTH) cycles, after which the block returns to IDLE.
REQ-025 Rejected requests (push when full, pop when empty, reserved op, or replace when compiled out) pulse err the cycle after acceptance and leave all state unchanged.
REQ-026 count, full, empty and top_key are registered and reflect the result of the accept cycle; top_key is final only once the block is back in IDLE.
REQ-027 All index arithmetic uses $clog2(DEPTH)+1 bits so that child indices cannot wrap.

Reset
REQ-028 Reset forces:
- state IDLE, count 0, empty 1, full 0;
- resp_valid 0, err 0, resp_key 0, top_key 0.
REQ-029 Reset asserted mid-sift abandons the operation; storage contents are not cleared and are treated as invalid.

Configuration
REQ-030 With `HEAP_REPLACE_EN` defined, op 10 on a non-empty heap returns arr[0] as in a pop, writes arr[0] <= req_key with count unchanged, then enters SIFT_DOWN; on an empty heap it behaves as a push with no resp_valid.
REQ-031 Without `HEAP_REPLACE_EN`, op 10 is rejected per REQ-025.

Structure
REQ-032 Package heap_pkg holds the op encodings (OP_PUSH, OP_POP, OP_REPLACE) and the FSM state enumeration.
REQ-033 The sub-module heap_cmp (the combinational Better() and best-of-two-children select, parametrised by DATA_W and MAX_HEAP) is instantiated for both sift directions.

Verification
REQ-034 MAX_HEAP=1: push 5, 9, 1, 7 -> top_key 9, count 4; four pops -> resp_key 9, 7, 5, 1, then empty 1.
REQ-035 MAX_HEAP=0: push 5, 9, 1 -> top_key 1; pop -> resp_key 1, then top_key 5.
REQ-036 DEPTH=4: push 4 keys, fifth push -> err pulse, count stays 4; pop on an empty heap -> err pulse, no resp_valid.
REQ-037 Duplicate keys: push 3, 3, 3; three pops -> resp_key 3 each time, no err.
REQ-038 Reset asserted during a SIFT_DOWN of an 8-entry heap -> count 0, req_ready 1 the next cycle; a new push of 2 -> top_key 2.
REQ-039 `HEAP_REPLACE_EN`, max-heap {8, 6, 4}: replace with 5 -> resp_key 8, top_key 6, count 3.
